// File: rtl/alu_front_stage.sv
// alu_front_stage / comb_alu_front
//
// Operand-steering front end of the ALU. Shift instructions reach the ALU
// core as a uniform (value, amount) pair:
//   sll/srl/sra    : out_1 = op2, out_2 = zero-extended shamt
//   sllv/srlv/srav : out_1 = op2, out_2 = zero-extended op1[4:0]
//   everything else: out_1 = op1, out_2 = op2
//
// comb_alu_front is the zero-latency steering function.
// alu_front_stage is that function followed by one output register stage.
//
// Ports (alu_front_stage):
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset; clears both outputs
//   aluop  in   [4:0]        ALU operation class from decode
//   func   in   [5:0]        R-type function field
//   shamt  in   [4:0]        R-type shift amount field
//   op1    in   [DATA_W-1:0] first source operand
//   op2    in   [DATA_W-1:0] second source operand
//   out_1  out  [DATA_W-1:0] steered first operand, registered
//   out_2  out  [DATA_W-1:0] steered second operand, registered
// comb_alu_front has the same ports without clk and rst_n. Its outputs are
// combinational.

module comb_alu_front #(
    parameter int          DATA_W   = 32,
    parameter logic [4:0]  RTYPE_OP = 5'b01001
) (
    input  logic [4:0]        aluop,
    input  logic [5:0]        func,
    input  logic [4:0]        shamt,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output logic [DATA_W-1:0] out_1,
    output logic [DATA_W-1:0] out_2
);
    always_comb begin
        out_1 = op1;
        out_2 = op2;
        if (aluop == RTYPE_OP) begin
            case (func)
                6'h00, 6'h02, 6'h03: begin
                    out_1 = op2;
                    out_2 = {{(DATA_W-5){1'b0}}, shamt};
                end
                // Variable shifts use only the low 5 bits of rs as the amount.
                6'h04, 6'h06, 6'h07: begin
                    out_1 = op2;
                    out_2 = {{(DATA_W-5){1'b0}}, op1[4:0]};
                end
                default: ;
            endcase
        end
    end
endmodule

module alu_front_stage #(
    parameter int          DATA_W   = 32,
    parameter logic [4:0]  RTYPE_OP = 5'b01001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        aluop,
    input  logic [5:0]        func,
    input  logic [4:0]        shamt,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output logic [DATA_W-1:0] out_1,
    output logic [DATA_W-1:0] out_2
);
    logic [DATA_W-1:0] n1, n2;

    comb_alu_front #(
        .DATA_W   (DATA_W),
        .RTYPE_OP (RTYPE_OP)
    ) u_steer (
        .aluop (aluop),
        .func  (func),
        .shamt (shamt),
        .op1   (op1),
        .op2   (op2),
        .out_1 (n1),
        .out_2 (n2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_1 <= '0;
            out_2 <= '0;
        end else begin
            out_1 <= n1;
            out_2 <= n2;
        end
    end
endmodule

// File: tb/tb_alu_front_stage.sv
module tb_alu_front_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  aluop = '0;
    logic [5:0]  func = '0;
    logic [4:0]  shamt = '0;
    logic [31:0] op1 = '0, op2 = '0;
    logic [31:0] out_1, out_2, c_out_1, c_out_2;

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] sb_q[$];
    logic [63:0] last_exp = '0;

    alu_front_stage dut (
        .clk(clk), .rst_n(rst_n), .aluop(aluop), .func(func), .shamt(shamt),
        .op1(op1), .op2(op2), .out_1(out_1), .out_2(out_2)
    );

    comb_alu_front dut_c (
        .aluop(aluop), .func(func), .shamt(shamt), .op1(op1), .op2(op2),
        .out_1(c_out_1), .out_2(c_out_2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference steering model, {N1, N2}
    function automatic logic [63:0] model(input logic [4:0] a, input logic [5:0] f,
                                          input logic [4:0] s, input logic [31:0] o1,
                                          input logic [31:0] o2);
        logic is_r;
        is_r = (a == 5'b01001);
        if (is_r && (f == 6'h00 || f == 6'h02 || f == 6'h03))
            return {o2, 27'd0, s};
        if (is_r && (f == 6'h04 || f == 6'h06 || f == 6'h07))
            return {o2, 27'd0, o1[4:0]};
        return {o1, o2};
    endfunction

    // Called #1 after a rising edge. Drives one input vector, checks the comb
    // variant and that the register holds, then checks the capture after the edge.
    task automatic cycle(input string tag, input logic [4:0] a, input logic [5:0] f,
                         input logic [4:0] s, input logic [31:0] o1, input logic [31:0] o2);
        logic [63:0] e;
        aluop = a; func = f; shamt = s; op1 = o1; op2 = o2;
        e = model(a, f, s, o1, o2);
        sb_q.push_back(e);
        #1;
        chk({tag, "_comb1"}, c_out_1, e[63:32]);
        chk({tag, "_comb2"}, c_out_2, e[31:0]);
        chk({tag, "_hold1"}, out_1, last_exp[63:32]);
        chk({tag, "_hold2"}, out_2, last_exp[31:0]);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_reg1"}, out_1, e[63:32]);
            chk({tag, "_reg2"}, out_2, e[31:0]);
            last_exp = e;
        end
    endtask

    // Asynchronous reset pulse taken mid-cycle, away from the clock edge.
    task automatic pulse_reset(input int cycles);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async1", out_1, 32'd0);
        chk("rst_async2", out_2, 32'd0);
        sb_q.delete();
        last_exp = '0;
        repeat (cycles) @(posedge clk);
        #1;
        chk("rst_held1", out_1, 32'd0);
        chk("rst_held2", out_2, 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        // The release happens well before this edge, but no new vector has been
        // driven since the reset, so the register is fed the current inputs.
        last_exp = model(aluop, func, shamt, op1, op2);
        chk("rst_first1", out_1, last_exp[63:32]);
        chk("rst_first2", out_2, last_exp[31:0]);
    endtask

    initial begin
        aluop = 5'b01001; func = 6'h03; shamt = 5'd7; op1 = 32'hDEADBEEF; op2 = 32'h12345678;
        #1 rst_n = 1'b0;
        #1;
        chk("reset1", out_1, 32'd0);
        chk("reset2", out_2, 32'd0);
        @(posedge clk); #1;
        chk("reset_edge1", out_1, 32'd0);
        chk("reset_edge2", out_2, 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        // First edge after release captures sra: op2, shamt.
        chk("first1", out_1, 32'h12345678);
        chk("first2", out_2, 32'd7);
        last_exp = {32'h12345678, 32'd7};

        cycle("sra",    5'b01001, 6'h03, 5'd5, 32'd17, 32'hFFFF0001);
        cycle("mult",   5'b01001, 6'h18, 5'd5, 32'd17, 32'hFFFF0001);
        cycle("srav",   5'b01001, 6'h07, 5'd9, 32'hFFFFFFE3, 32'h80000000);
        cycle("nonr",   5'b00000, 6'h00, 5'd31, 32'd1, 32'd2);
        cycle("sll",    5'b01001, 6'h00, 5'd31, 32'hAAAA5555, 32'h0F0F0F0F);
        cycle("srl",    5'b01001, 6'h02, 5'd0, 32'h1, 32'hFFFFFFFF);
        cycle("sllv",   5'b01001, 6'h04, 5'd3, 32'hFFFFFFFF, 32'h00000042);
        cycle("srlv",   5'b01001, 6'h06, 5'd3, 32'h00000020, 32'h00000042);
        cycle("undef1", 5'b01001, 6'h01, 5'd3, 32'h11111111, 32'h22222222);
        cycle("undef5", 5'b01001, 6'h05, 5'd3, 32'h33333333, 32'h44444444);
        cycle("near_r", 5'b01000, 6'h04, 5'd3, 32'h55555555, 32'h66666666);

        for (int i = 0; i < 1000; i++) begin
            logic [4:0] a;
            logic [5:0] f;
            a = ($urandom_range(0, 1) == 1) ? 5'b01001 : 5'($urandom);
            f = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7)) : 6'($urandom);
            cycle("rand", a, f, 5'($urandom), $urandom, $urandom);
            if ($urandom_range(0, 49) == 0) pulse_reset(int'($urandom_range(1, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule

// File: doc/alu_front_stage.md
Name: alu_front_stage

Overview:
Operand-steering front end of the MIPS ALU. It sits between register-read/decode and the ALU core, and reorders/rewrites the two ALU operands so the core sees a uniform "value, amount" pair for shift instructions. It contains a combinational steering function followed by one output register stage. The combinational function alone is the comb_alu_front variant, and it must give identical values with zero latency.

Parameters:
DATA_W, 32, operand/result width (only 32 supported)
RTYPE_OP, 5'b01001, aluop code meaning "R-type, decode func field"

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
aluop  input  5  ALU operation class from decode
func  input  6  R-type function field (instr[5:0])
shamt  input  5  R-type shift amount field (instr[10:6])
op1  input  32  first source operand (rs value or equivalent)
op2  input  32  second source operand (rt value or immediate)
out_1  output  32  steered first ALU operand
out_2  output  32  steered second ALU operand

Behaviour:
- Clock/reset: one clock (clk); reset asynchronous, active-low (rst_n).
- Combinational steering function (N1, N2), evaluated every cycle.
- Constant-shift group (aluop == RTYPE_OP and func ∈ {6'h00 sll, 6'h02 srl, 6'h03 sra}):
  - N1 = op2.
  - N2 = {27'b0, shamt}.
- Variable-shift group (aluop == RTYPE_OP and func ∈ {6'h04 sllv, 6'h06 srlv, 6'h07 srav}):
  - N1 = op2.
  - N2 = {27'b0, op1[4:0]}; op1[31:5] are ignored.
- Every other case: N1 = op1, N2 = op2 (pure pass-through). This covers:
  - other func values under RTYPE_OP: add, sub, mult 6'h18, div, jr, undefined codes (e.g. 6'h01, 6'h05);
  - all other aluop values.
- No arithmetic is done; values are never sign-extended; shamt is always zero-extended.
- Outputs are registered:
  - On rising clk with rst_n high: out_1 <= N1, out_2 <= N2.
  - Latency is exactly 1 cycle; throughput is 1 per cycle; there is no handshake or stall.
- Reset:
  - While rst_n is low, out_1 = 0 and out_2 = 0, immediately and regardless of clk.
  - The first capture happens at the first rising clk after rst_n deasserts.
  - Reset asserted mid-stream discards the in-flight value.
- Input changes between edges do not affect the outputs until the next rising edge.
- No internal state other than the two 32-bit output registers.
- comb variant:
  - Same ports minus clk/rst_n.
  - out_1 = N1, out_2 = N2 continuously.
  - The registered block output at cycle n+1 must equal the comb output at cycle n.

Test Plan:
1. rst_n=0 with arbitrary inputs -> out_1=0, out_2=0 asynchronously. Release rst_n -> first edge loads N1/N2.
2. aluop=5'b01001, func=3 (sra), shamt=5, op1=17, op2=32'hFFFF0001 -> after one edge out_1=32'hFFFF0001, out_2=5. Comb variant gives the same values with no delay.
3. Same operands, func switched to 6'h18 (mult) mid-run -> next edge out_1=17, out_2=32'hFFFF0001. Outputs hold the previous values until that edge.
4. aluop=5'b01001, func=6'h07 (srav), op1=32'hFFFFFFE3, op2=32'h80000000, shamt=9 -> out_1=32'h80000000, out_2=3 (op1[4:0] used, shamt ignored).
5. aluop=5'b00000, func=6'h00, shamt=31, op1=1, op2=2 -> out_1=1, out_2=2 (non-R-type passes through even though func looks like sll).
6. Random aluop/func/shamt/op1/op2 for 1000 cycles, rst_n pulsed low at random points -> registered outputs equal the comb model delayed one cycle, and are 0 while in reset.
